mod_reduce_256: RTL and testbench

- Downstream consumer of the 256-bit adder in the ECDSA field-arithmetic path.
- Accepts the 257-bit raw sum {cout, s} and returns the fully reduced value r = (cout·2^256 + s) mod P.
- Uses a limb-serial conditional subtraction of P.
- Precondition: the input is below 2P, which holds when both addends are below P. Output feeds the next field-arithmetic stage.

---
 rtl/ecdsa_pkg.sv | 17 +
 rtl/mod_reduce_256_limb_sub.sv | 20 ++
 rtl/mod_reduce_256.sv | 163 ++++++++++++++++
 tb/tb_mod_reduce_256.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA field-arithmetic path: field width,
// the secp256k1 modulus, default limb width and the reducer state type.
package ecdsa_pkg;

    localparam int FIELD_W    = 256;
    localparam int LIMB_W_DEF = 64;

    localparam logic [FIELD_W-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_reduce_256_limb_sub.sv
// limb_sub: combinational W-bit subtractor with borrow-in / borrow-out.
// d_o = a_i - b_i - bin_i (mod 2^W); bout_o = 1 when the true result is negative.
module limb_sub #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] d_o,
    output logic         bout_o
);

    logic [W:0] wide;

    // Extend by one bit; the extra MSB becomes the borrow out.
    assign wide   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
    assign d_o    = wide[W-1:0];
    assign bout_o = wide[W];

endmodule

// File: rtl/mod_reduce_256.sv
// mod_reduce_256: reduces a raw 257-bit adder result {cout, sum} modulo P
// with a limb-serial trial subtraction of P, one LIMB_W slice per cycle.
// The input must be below 2P, so a single conditional subtraction suffices.
// Optional feature macro: MOD_REDUCE_FLAG_EN adds output 'reduced', which
// reports whether P was subtracted for the current result.
// WIDTH must be a multiple of LIMB_W.
module mod_reduce_256
    import ecdsa_pkg::*;
#(
    parameter int                WIDTH  = FIELD_W,
    parameter int                LIMB_W = LIMB_W_DEF,
    parameter logic [WIDTH-1:0]  P      = WIDTH'(SECP256K1_P)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] r,
    output logic             valid_out,
    input  logic             ready_in
`ifdef MOD_REDUCE_FLAG_EN
    ,
    output logic             reduced
`endif
);

    localparam int NLIMB = WIDTH / LIMB_W;
    localparam int KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NLIMB - 1);

    typedef logic [NLIMB-1:0][LIMB_W-1:0] limbs_t;

    localparam limbs_t P_LIMB = P;

    state_e           state_q, state_d;
    logic [WIDTH:0]   x_q, x_d;
    logic [KW-1:0]    k_q, k_d;
    logic             borrow_q, borrow_d;
    limbs_t           diff_q, diff_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             valid_q, valid_d;

    limbs_t           x_limb;
    logic [LIMB_W-1:0] sub_d;
    logic             sub_bout;
    logic             last_limb;
    logic             take_diff;

    assign x_limb = x_q[WIDTH-1:0];

    limb_sub #(
        .W (LIMB_W)
    ) u_limb_sub (
        .a_i    (x_limb[k_q]),
        .b_i    (P_LIMB[k_q]),
        .bin_i  (borrow_q),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    assign last_limb = (k_q == K_LAST);
    // x >= P exactly when the carry bit is set or the full-width
    // subtraction finished without a borrow.
    assign take_diff = x_q[WIDTH] | ~sub_bout;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            r_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            r_q      <= r_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: accept in IDLE, one limb per cycle in SUB,
    // hold the result in DONE until the downstream handshake.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        k_d       = k_q;
        borrow_d  = borrow_q;
        diff_d    = diff_q;
        r_d       = r_q;
        valid_d   = valid_q;
        ready_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    x_d      = {cout, sum};
                    k_d      = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                diff_d[k_q] = sub_d;
                borrow_d    = sub_bout;
                k_d         = k_q + KW'(1);
                if (last_limb) begin
                    // diff_d already holds the final limb, so it is the
                    // complete x - P when the subtraction is kept.
                    r_d     = take_diff ? diff_d : x_q[WIDTH-1:0];
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign r         = r_q;
    assign valid_out = valid_q;

`ifdef MOD_REDUCE_FLAG_EN
    logic flag_q, flag_d;

    // Flag tracks whether P was subtracted; valid alongside valid_out.
    always_comb begin
        flag_d = flag_q;
        if (state_q == ST_SUB && last_limb) begin
            flag_d = take_diff;
        end else if (state_q == ST_DONE && ready_in) begin
            flag_d = 1'b0;
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign reduced = flag_q;
`endif

endmodule

// File: tb/tb_mod_reduce_256.sv
// Self-checking bench for mod_reduce_256: table of vectors with expected
// results, a scoreboard queue, and hand-written backpressure / reset sequences.
module tb_mod_reduce_256;

    localparam logic [255:0] P_TB =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int NVEC = 14;

    logic         clk;
    logic         reset;
    logic [255:0] sum;
    logic         cout;
    logic         valid_in;
    logic         ready_out;
    logic [255:0] r;
    logic         valid_out;
    logic         ready_in;
`ifdef MOD_REDUCE_FLAG_EN
    logic         reduced;
`endif

    mod_reduce_256 dut (
        .clk       (clk),
        .reset     (reset),
        .sum       (sum),
        .cout      (cout),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .r         (r),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef MOD_REDUCE_FLAG_EN
        ,
        .reduced   (reduced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] s;
        logic         c;
        logic [255:0] er;
        logic         ef;
    } vec_t;

    typedef struct packed {
        logic [255:0] r;
        logic         f;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Reference: single conditional subtraction on the full 257-bit value.
    function automatic void model(input logic [255:0] s, input logic c,
                                  output logic [255:0] er, output logic ef);
        logic [256:0] x;
        logic [256:0] t;
        x = {c, s};
        if (x >= {1'b0, P_TB}) begin
            t  = x - {1'b0, P_TB};
            er = t[255:0];
            ef = 1'b1;
        end else begin
            er = s;
            ef = 1'b0;
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard: compare each result on the cycle its handshake completes.
    always @(negedge clk) begin
        exp_t e;
        if (reset && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got r=%h, required no output", r);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                $display("txn %0d r=%h expected=%h", n_out, r, e.r);
                check("result_r", r, e.r);
`ifdef MOD_REDUCE_FLAG_EN
                check("result_reduced", 256'(reduced), 256'(e.f));
`endif
            end
        end
    end

    // Count negedges after the accepting edge until valid_out appears.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_out && lat < 20);
    endtask

    // One full operation with ready_in held high; called at posedge+2.
    task automatic do_op(input logic [255:0] s, input logic c,
                         input logic [255:0] er, input logic ef);
        int n;
        int lat;
        n = 0;
        while (!ready_out && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("ready_before_op", 256'(ready_out), 256'(1));
        sum      = s;
        cout     = c;
        valid_in = 1'b1;
        exp_q.push_back('{r: er, f: ef});
        @(posedge clk); #2;
        valid_in = 1'b0;
        sum      = rand256();
        cout     = 1'($urandom);
        check("busy_after_accept", 256'(ready_out), 256'(0));
        wait_result(lat);
        check("latency", 256'(lat), 256'(5));
        @(posedge clk); #2;
        check("valid_one_cycle", 256'(valid_out), 256'(0));
        check("ready_back", 256'(ready_out), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{256'h5, 1'b0, 256'h5, 1'b0};
        vecs[1] = '{P_TB, 1'b0, 256'h0, 1'b1};
        vecs[2] = '{P_TB - 256'd1, 1'b0, P_TB - 256'd1, 1'b0};
        vecs[3] = '{256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFD_FFFFF85C, 1'b1,
                    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D, 1'b1};
        vecs[4] = '{256'h0, 1'b0, 256'h0, 1'b0};
        vecs[5] = '{P_TB + 256'd1, 1'b0, 256'h1, 1'b1};
        vecs[6] = '{{256{1'b1}}, 1'b0, 256'h1_000003D0, 1'b1};
        vecs[7] = '{256'h0, 1'b1, 256'h1_000003D1, 1'b1};
        // Random vectors below 2P, expectations from the reference model.
        for (int i = 8; i < NVEC; i++) begin
            vecs[i].s = rand256();
            vecs[i].c = 1'($urandom);
            if (vecs[i].c) vecs[i].s[255] = 1'b0;
            model(vecs[i].s, vecs[i].c, vecs[i].er, vecs[i].ef);
        end

        reset    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        sum      = '0;
        cout     = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("reset_r", r, 256'h0);
        check("reset_valid_out", 256'(valid_out), 256'(0));
        check("reset_ready_out", 256'(ready_out), 256'(1));
`ifdef MOD_REDUCE_FLAG_EN
        check("reset_reduced", 256'(reduced), 256'(0));
`endif
        reset = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].s, vecs[i].c, vecs[i].er, vecs[i].ef);
        end

        // Backpressure: result A held while new data B is offered.
        ready_in = 1'b0;
        sum      = P_TB + 256'd7;
        cout     = 1'b0;
        valid_in = 1'b1;
        exp_q.push_back('{r: 256'd7, f: 1'b1});
        @(posedge clk); #2;
        sum = 256'd123;
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_result_ready", 256'(valid_out), 256'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_r_stable", r, 256'd7);
            check("bp_valid_held", 256'(valid_out), 256'(1));
            check("bp_ready_low", 256'(ready_out), 256'(0));
        end
        @(posedge clk); #2;
        ready_in = 1'b1;
        exp_q.push_back('{r: 256'd123, f: 1'b0});
        @(posedge clk); #2;
        check("bp_idle_valid", 256'(valid_out), 256'(0));
        check("bp_idle_ready", 256'(ready_out), 256'(1));
        @(posedge clk); #2;
        check("bp_b_accepted", 256'(ready_out), 256'(0));
        valid_in = 1'b0;
        sum      = rand256();
        wait_result(lat);
        check("bp_b_latency", 256'(lat), 256'(5));
        @(posedge clk); #2;

        // Reset during SUB with k=2: asynchronous return to reset values.
        sum      = P_TB + 256'd9;
        cout     = 1'b0;
        valid_in = 1'b1;
        @(posedge clk); #2;
        valid_in = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_r", r, 256'h0);
        check("abort_valid_out", 256'(valid_out), 256'(0));
        check("abort_ready_out", 256'(ready_out), 256'(1));
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        do_op(256'h5, 1'b0, 256'h5, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
